wb_lut_round_engine: RTL and testbench
======================================

# wb_lut_round_engine

Parametrised white-box table-lookup round engine: the generalised successor to the fixed 128-bit, single-round-function white-box datapath. It holds an NBYTE-byte state and runs NROUND T-box style rounds. Each round replaces the state with the XOR of NBYTE table entries, one per state byte, indexed by {round, byte position, byte value}. Tables are loaded through a configuration write port while the engine is idle. Plaintext enters and ciphertext leaves over valid/ready handshakes.

## Interface
- NBYTE, 16, state bytes; DW = 8*NBYTE
- NROUND, 2, rounds per block (≥1); RW = max(1,$clog2(NROUND))
- AW, derived = RW + $clog2(NBYTE) + 8; table depth NROUND*NBYTE*256 (8192 at defaults)
- clk input 1: single clock, all state on rising edge
- rst input 1: reset, asynchronous, active-high
- cfg_we input 1: table write strobe
- cfg_addr input AW: {round, byte_idx, byte_value}
- cfg_data input DW: table entry
- cfg_err output 1: one-cycle pulse, cfg_we rejected
- in_valid input 1 / in_ready output 1 / in_data input DW: plaintext
- out_valid output 1 / out_ready input 1 / out_data output DW: result
- busy output 1: high in RUN, DRAIN, DONE
- round_o output RW: current round index

## Operation
- Byte i of the state is state[8i+7:8i]. Lookup address is {r, i, state_i}.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = ~cfg_we. Handshake (in_valid&in_ready) loads state<=in_data, r<=0, i<=0, acc<=0 → RUN.
  - cfg_we writes cfg_data at cfg_addr. cfg_we has priority over in_valid in the same cycle; no accept that cycle.
- RUN: issue read {r,i,state_i}, i++. Read data arrives one cycle later and acc ^= q. After issuing i=NBYTE-1 → DRAIN.
- DRAIN:
  - state <= acc ^ q_last (see Configuration), acc<=0, i<=0.
  - If r==NROUND-1: → DONE, out_data<=new state.
  - Otherwise: r++ → RUN.
- DONE: out_valid=1, out_data stable until out_ready. On the handshake → IDLE.
- cfg_we outside IDLE: no write, cfg_err pulses the following cycle.
- Reset (any time, including mid-block): FSM→IDLE, state, acc, r, i, out_data cleared. Table contents undefined and not cleared; the in-flight block is lost.

## Timing
- Reset values: in_ready=1 (when cfg_we=0), out_valid=0, out_data=0, busy=0, cfg_err=0, round_o=0.
- Table read latency: 1 cycle (synchronous single-port).
- Per round: NBYTE+1 cycles (NBYTE RUN cycles plus 1 DRAIN cycle).
- out_valid rises NROUND*(NBYTE+1)+1 cycles after the accept edge; 35 at defaults.
- in_ready=0 from the accept until the cycle after the output handshake. Minimum block-to-block spacing is therefore latency+1 cycles.
- A cfg write issued in IDLE is visible to a block accepted on the next cycle.

## Configuration
- WB_RK_XOR_EN defined:
  - Adds input rk_i [DW] and output rk_req [1].
  - rk_req is high during DRAIN.
  - rk_i is sampled in DRAIN, and the round update becomes state <= acc ^ q_last ^ rk_i.
- Undefined: ports absent, state <= acc ^ q_last.

## Structure
- Package wb_lut_pkg holds:
  - FSM state enum (2-bit).
  - Default NBYTE/NROUND.
  - Address-packing helper function, {r,i,v} → AW.
- Sub-module wb_lut_sram: behavioural single-port synchronous RAM, DW×2^AW, one write or one read per cycle, registered Q.
- The engine muxes the RAM address between cfg_addr (IDLE) and the lookup address (RUN).

## Test plan
- Identity tables (LUT[r][i][v] = v<<8i, r=0,1), in_data=128'h00112233445566778899AABBCCDDEEFF → out_data equals in_data, out_valid exactly 35 cycles after accept.
- Constant tables (LUT[r][i][v]=128'h1 for i=0, 0 otherwise) → out_data=128'h1 for any input; round_o steps 0→1 at cycle 17.
- cfg_we pulsed during RUN at addr 0 with data all-ones → cfg_err=1 next cycle. A following identity-table block still returns its input unchanged.
- cfg_we and in_valid both high in IDLE → write performed, in_ready=0, no accept. in_valid held → accept next cycle.
- out_ready held low 10 cycles after out_valid → out_data/out_valid stable. in_ready=0 throughout; in_ready=1 in the cycle after the handshake.
- rst asserted at round 1, i=5 → next cycle out_valid=0, busy=0, round_o=0, in_ready=1. With WB_RK_XOR_EN and identity tables, rk_i=128'h01 → output = input ^ 128'h01 ^ 128'h01 = input; rk_i=round-dependent values XOR accordingly.

Source files
------------

// File: rtl/wb_lut_pkg.sv
// wb_lut_pkg: shared types and helpers for the white-box table-lookup round
// engine.
//   eng_state_t : 2-bit engine FSM state (IDLE, RUN, DRAIN, DONE)
//   DEF_NBYTE   : default number of state bytes
//   DEF_NROUND  : default number of rounds per block
//   pack_addr() : packs {round, byte index, byte value} into a table address
package wb_lut_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } eng_state_t;

   localparam int DEF_NBYTE  = 16;
   localparam int DEF_NROUND = 2;

   // Returns a 32-bit value. The caller truncates it to its own address width.
   // ibits is the width of the byte-index field.
   function automatic logic [31:0] pack_addr(input logic [31:0] r,
                                             input logic [31:0] i,
                                             input logic [7:0]  v,
                                             input int          ibits);
      return (r << (ibits + 8)) | (i << 8) | {24'd0, v};
   endfunction

endpackage

// File: rtl/wb_lut_sram.sv
// wb_lut_sram: behavioural single-port synchronous RAM that holds the lookup
// tables.
//   clk   : clock
//   we    : write strobe. When it is low, the cycle is a read.
//   addr  : word address (AW bits)
//   wdata : write data (DW bits)
//   q     : registered read data. It is valid one cycle after a read and
//           holds its value through a write cycle.
// The RAM has no reset, so its contents are undefined until software loads
// them.
module wb_lut_sram #(
   parameter int AW = 13,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
   end

endmodule

// File: rtl/wb_lut_round_engine.sv
// wb_lut_round_engine: white-box T-box style round engine.
// The engine holds an NBYTE-byte state and runs NROUND rounds. In each round,
// every state byte i looks up table entry {r, i, state_i}, and the new state is
// the XOR of those NBYTE entries.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_we/addr/data  : table write port. Writes are accepted only in IDLE.
//   cfg_err           : one-cycle pulse after a write that was rejected
//                       because the engine was not idle
//   in_valid/ready/data    : plaintext input
//   out_valid/ready/data   : result output
//   rk_i, rk_req      : (WB_RK_XOR_EN only) round key. It is requested and
//                       sampled in DRAIN.
//   busy              : high whenever the engine is not idle
//   round_o           : current round index
//   fsm_state         : current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high, the source holds its data. A sink may hold
// ready low for any number of cycles. out_data stays stable while out_valid is
// waiting for out_ready.
//
// Build option: define WB_RK_XOR_EN to XOR in a per-round key rk_i.
module wb_lut_round_engine
   import wb_lut_pkg::*;
#(
   parameter  int NBYTE  = DEF_NBYTE,
   parameter  int NROUND = DEF_NROUND,
   localparam int DW     = 8 * NBYTE,
   localparam int RW     = (NROUND > 1) ? $clog2(NROUND) : 1,
   localparam int IBITS  = $clog2(NBYTE),
   localparam int CW     = (NBYTE > 1) ? IBITS : 1,
   localparam int AW     = RW + IBITS + 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   output logic          cfg_err,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
`ifdef WB_RK_XOR_EN
   input  logic [DW-1:0] rk_i,
   output logic          rk_req,
`endif
   output logic          busy,
   output logic [RW-1:0] round_o,
   output eng_state_t    fsm_state
);

   eng_state_t    cur, nxt;
   logic [DW-1:0] state_q, acc_q, out_q;
   logic [RW-1:0] r_q;
   logic [CW-1:0] i_q;
   logic          cfg_err_q;

   logic          ram_we;
   logic [AW-1:0] ram_addr, lut_addr;
   logic [DW-1:0] ram_q, round_val;
   logic [7:0]    cur_byte;
   logic          last_byte, last_round, accept;

   assign cur_byte   = state_q[8*i_q +: 8];
   assign lut_addr   = AW'(pack_addr(32'(r_q), 32'(i_q), cur_byte, IBITS));
   assign last_byte  = (i_q == CW'(NBYTE - 1));
   assign last_round = (r_q == RW'(NROUND - 1));
   // A table write takes the RAM port, so it blocks an input accept in the
   // same cycle.
   assign accept     = (cur == S_IDLE) && in_valid && !cfg_we;
   assign ram_we     = (cur == S_IDLE) && cfg_we;
   assign ram_addr   = (cur == S_IDLE) ? cfg_addr : lut_addr;

   // In DRAIN, ram_q holds the entry for the last byte, which acc_q has not
   // absorbed yet.
`ifdef WB_RK_XOR_EN
   assign round_val = acc_q ^ ram_q ^ rk_i;
   assign rk_req    = (cur == S_DRAIN);
`else
   assign round_val = acc_q ^ ram_q;
`endif

   wb_lut_sram #(.AW(AW), .DW(DW)) u_sram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (cfg_data),
      .q     (ram_q)
   );

   always_comb begin
      nxt       = cur;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (cur)
         S_IDLE: begin
            in_ready = ~cfg_we;
            if (accept) nxt = S_RUN;
         end
         S_RUN:   if (last_byte) nxt = S_DRAIN;
         S_DRAIN: nxt = last_round ? S_DONE : S_RUN;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= S_IDLE;
         state_q   <= '0;
         acc_q     <= '0;
         out_q     <= '0;
         r_q       <= '0;
         i_q       <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cur       <= nxt;
         cfg_err_q <= cfg_we && (cur != S_IDLE);
         case (cur)
            S_IDLE: if (accept) begin
               state_q <= in_data;
               r_q     <= '0;
               i_q     <= '0;
               acc_q   <= '0;
            end
            S_RUN: begin
               i_q <= i_q + 1'b1;
               // ram_q holds the entry for byte i-1. At i==0 it holds stale
               // data from the previous round or from idle reads.
               if (i_q != '0) acc_q <= acc_q ^ ram_q;
            end
            S_DRAIN: begin
               state_q <= round_val;
               acc_q   <= '0;
               i_q     <= '0;
               if (last_round) out_q <= round_val;
               else            r_q   <= r_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cfg_err   = cfg_err_q;
   assign out_data  = out_q;
   assign busy      = (cur != S_IDLE);
   assign round_o   = r_q;
   assign fsm_state = cur;

endmodule

// File: tb/tb_wb_lut_round_engine.sv
`timescale 1ns/1ps
module tb_wb_lut_round_engine;
   import wb_lut_pkg::*;

   localparam int DW  = 128;
   localparam int AW  = 13;
   localparam int LAT = 35;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic          cfg_err;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          busy;
   logic [0:0]    round_o;
   eng_state_t    fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

`ifdef WB_RK_XOR_EN
   logic [DW-1:0] rk_i;
   logic          rk_req;
   int            rk_mode = 0;
   always_comb begin
      rk_i = '0;
      if (rk_mode == 1)      rk_i = 128'h01;
      else if (rk_mode == 2) rk_i = round_o[0] ? 128'h20 : 128'h03;
   end
`endif

   wb_lut_round_engine dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef WB_RK_XOR_EN
      .rk_i      (rk_i),
      .rk_req    (rk_req),
`endif
      .busy      (busy),
      .round_o   (round_o),
      .fsm_state (fsm_state)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_lut(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   // mode 0: identity  LUT[r][i][v] = v << 8i
   // mode 1: constant  LUT[r][i][v] = 1 for i==0, else 0
   task automatic load_tables(input int mode);
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 16; i++)
            for (int v = 0; v < 256; v++) begin
               a = {r[0], i[3:0], v[7:0]};
               if (mode == 0) begin
                  d = DW'(v);
                  d = d << (8 * i);
               end else begin
                  d = (i == 0) ? 128'h1 : 128'h0;
               end
               write_lut(a, d);
            end
   endtask

   // Precondition: engine idle and cfg_we low, so the block is accepted on the
   // first edge.
   task automatic start_block(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // Starts a block, waits (bounded) for out_valid and takes the result.
   // lat is the number of the first cycle after the accept edge in which
   // out_valid is high. Cycle 1 follows the accept edge directly.
   task automatic send_block(input logic [DW-1:0] d, output logic [DW-1:0] res,
                             output int lat, output logic r17, output logic r18);
      r17 = 1'bx;
      r18 = 1'bx;
      start_block(d);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 17) r17 = round_o[0];
         if (lat == 18) r18 = round_o[0];
      end while (!out_valid && lat < 200);
      res       = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (cfg_err !== 1'b0)   begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
      n_checks++; if (round_o !== 1'b0)   begin n_fail++; $display("FAIL reset_round_o: got %b want 0", round_o); end
      n_checks++; if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_fsm_state: got %0d want 0", fsm_state); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      logic [DW-1:0] vec [2];
      logic [DW-1:0] res;
      int            lat;
      logic          r17, r18;
      vec[0] = 128'h00112233445566778899AABBCCDDEEFF;
      vec[1] = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
      load_tables(0);
      for (int k = 0; k < 2; k++) begin
         send_block(vec[k], res, lat, r17, r18);
         n_checks++; if (res !== vec[k]) begin n_fail++; $display("FAIL identity_data[%0d]: got %h want %h", k, res, vec[k]); end
         n_checks++; if (lat != LAT)     begin n_fail++; $display("FAIL identity_latency[%0d]: got %0d want %0d", k, lat, LAT); end
      end
   endtask

   task automatic test_cfg_err_in_run();
      logic [DW-1:0] d;
      int            k;
      d = 128'h0123456789ABCDEFFEDCBA9876543200;
      start_block(d);
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL run_busy: got %b want 1", busy); end
      n_checks++; if (fsm_state !== S_RUN) begin n_fail++; $display("FAIL run_state: got %0d want 1", fsm_state); end
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_data = '1;
      tick();
      cfg_we   = 1'b0;
      @(negedge clk);
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
      tick();
      @(negedge clk);
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
      k = 0;
      while (!out_valid && k < 100) begin @(negedge clk); k++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cfg_err_timeout: out_valid got %b want 1", out_valid); end
      n_checks++; if (out_data !== d)     begin n_fail++; $display("FAIL cfg_err_data: got %h want %h", out_data, d); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_cfg_priority();
      logic [DW-1:0] d, exp;
      int            lat;
      d   = 128'h00112233445566778899AABBCCDDEEFF;
      // Entry {r0, byte0, 0xFF} becomes 0, so byte 0 collapses to 00.
      exp = 128'h00112233445566778899AABBCCDDEE00;
      cfg_we   = 1'b1;
      cfg_addr = 13'h00FF;
      cfg_data = '0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prio_in_ready_low: got %b want 0", in_ready); end
      tick();
      cfg_we = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL prio_in_ready_high: got %b want 1", in_ready); end
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL prio_no_accept: busy got %b want 0", busy); end
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
      n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL prio_data: got %h want %h", out_data, exp); end
      n_checks++; if (lat != LAT)       begin n_fail++; $display("FAIL prio_latency: got %0d want %0d", lat, LAT); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      write_lut(13'h00FF, 128'hFF);
   endtask

   task automatic test_stall();
      logic [DW-1:0] d;
      int            k;
      d = 128'hA5A55A5A0F0FF0F01234567890ABCDEF;
      start_block(d);
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 200);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: out_valid got %b want 1", out_valid); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
         n_checks++; if (out_data !== d)     begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", c, out_data, d); end
         n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_hs_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_hs_out_valid: got %b want 0", out_valid); end
      tick();
   endtask

   task automatic test_reset_mid_block();
      logic [DW-1:0] d, res;
      int            lat;
      logic          r17, r18;
      d = 128'hFEEDFACE00000000C0FFEE0011223344;
      start_block(d);
      repeat (22) tick();
      @(negedge clk);
      n_checks++; if (round_o !== 1'b1) begin n_fail++; $display("FAIL midrst_round_before: got %b want 1", round_o); end
      n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_checks++; if (round_o !== 1'b0)   begin n_fail++; $display("FAIL midrst_round_o: got %b want 0", round_o); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
      tick();
      d = 128'h11111111222222223333333344444444;
      send_block(d, res, lat, r17, r18);
      n_checks++; if (res !== d)   begin n_fail++; $display("FAIL midrst_recover_data: got %h want %h", res, d); end
      n_checks++; if (lat != LAT)  begin n_fail++; $display("FAIL midrst_recover_latency: got %0d want %0d", lat, LAT); end
   endtask

`ifdef WB_RK_XOR_EN
   task automatic test_round_key();
      logic [DW-1:0] d, res;
      int            lat;
      logic          r17, r18;
      d = 128'h00112233445566778899AABBCCDDEEFF;
      rk_mode = 1;
      send_block(d, res, lat, r17, r18);
      n_checks++; if (res !== d) begin n_fail++; $display("FAIL rk_const_data: got %h want %h", res, d); end
      rk_mode = 2;
      start_block(d);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 16) begin n_checks++; if (rk_req !== 1'b0) begin n_fail++; $display("FAIL rk_req_run: got %b want 0", rk_req); end end
         if (lat == 17) begin n_checks++; if (rk_req !== 1'b1) begin n_fail++; $display("FAIL rk_req_drain: got %b want 1", rk_req); end end
      end while (!out_valid && lat < 200);
      n_checks++; if (out_data !== (d ^ 128'h23)) begin n_fail++; $display("FAIL rk_round_data: got %h want %h", out_data, d ^ 128'h23); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      rk_mode = 0;
   endtask
`endif

   task automatic test_constant();
      logic [DW-1:0] vec [2];
      logic [DW-1:0] res;
      int            lat;
      logic          r17, r18;
      vec[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
      vec[1] = 128'hFFFFFFFFFFFFFFFF0000000000000000;
      load_tables(1);
      for (int k = 0; k < 2; k++) begin
         send_block(vec[k], res, lat, r17, r18);
         n_checks++; if (res !== 128'h1) begin n_fail++; $display("FAIL const_data[%0d]: got %h want 1", k, res); end
         n_checks++; if (lat != LAT)     begin n_fail++; $display("FAIL const_latency[%0d]: got %0d want %0d", k, lat, LAT); end
         if (k == 0) begin
            n_checks++; if (r17 !== 1'b0) begin n_fail++; $display("FAIL round_o_cycle17: got %b want 0", r17); end
            n_checks++; if (r18 !== 1'b1) begin n_fail++; $display("FAIL round_o_cycle18: got %b want 1", r18); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_cfg_err_in_run();
      test_cfg_priority();
      test_stall();
      test_reset_mid_block();
`ifdef WB_RK_XOR_EN
      test_round_key();
`endif
      test_constant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
